// File: rtl/write_pointer_level_generate_pkg.sv
// rtl/write_pointer_level_generate_pkg.sv - shared FIFO pointer helpers (depth, Gray/binary conversion)
// Reused by both the write-side and read-side pointer blocks.
package write_pointer_level_generate_pkg;

  function automatic int fifo_depth(input int address_size);
    return 1 << address_size;
  endfunction

  function automatic logic [31:0] binary_to_gray(input logic [31:0] binary);
    return (binary >> 1) ^ binary;
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs convert correctly.
  function automatic logic [31:0] gray_to_binary_fn(input logic [31:0] gray);
    logic [31:0] binary;
    binary[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      binary[i] = binary[i+1] ^ gray[i];
    end
    return binary;
  endfunction

endpackage

// File: rtl/write_pointer_level_generate_gray_to_binary.sv
// rtl/write_pointer_level_generate_gray_to_binary.sv - combinational Gray-to-binary converter
// Width-parametrised wrapper around the shared conversion function.
module gray_to_binary
  import write_pointer_level_generate_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  assign binary = WIDTH'(gray_to_binary_fn(32'(gray)));

endmodule

// File: rtl/write_pointer_level_generate.sv
// rtl/write_pointer_level_generate.sv - async FIFO write-side pointer, level and flag generation
// Registers the Gray write pointer and derives full/almost-full/level from the synchronised read pointer.
module write_pointer_level_generate
  import write_pointer_level_generate_pkg::*;
#(
  parameter int ADDRESS_SIZE      = 4,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                    write_clk,
  input  logic                    write_reset,
  input  logic                    write_inc,
  input  logic [ADDRESS_SIZE:0]   synchronized_read_pointer2,
  input  logic                    overflow_clear,
  output logic                    write_accept,
  output logic [ADDRESS_SIZE-1:0] write_address,
  output logic [ADDRESS_SIZE:0]   write_gray_pointer,
  output logic                    write_full,
  output logic                    write_almost_full,
  output logic [ADDRESS_SIZE:0]   write_level,
  output logic                    write_overflow
);

  localparam int DEPTH = fifo_depth(ADDRESS_SIZE);
  localparam int PW    = ADDRESS_SIZE + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);

  generate
    if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH || ADDRESS_SIZE < 2) begin : g_bad_params
      $error("write_pointer_level_generate: ALMOST_FULL_LEVEL must be within 1..DEPTH");
    end
  endgenerate

  logic [PW-1:0] write_binary_count;
  logic [PW-1:0] binary_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] read_binary;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_pattern;
  logic          full_next;
  logic          almost_full_next;

  gray_to_binary #(.WIDTH(PW)) u_read_g2b (
    .gray   (synchronized_read_pointer2),
    .binary (read_binary)
  );

  assign write_accept  = write_inc & ~write_full;
  assign write_address = write_binary_count[ADDRESS_SIZE-1:0];
  assign binary_next   = write_binary_count + {{ADDRESS_SIZE{1'b0}}, write_accept};
  assign gray_next     = PW'(binary_to_gray(32'(binary_next)));
  assign level_next    = binary_next - read_binary;

  // Full when the write pointer is exactly one lap ahead: Gray MSB pair inverted.
  assign full_pattern     = {~synchronized_read_pointer2[PW-1:PW-2], synchronized_read_pointer2[PW-3:0]};
  assign full_next        = (gray_next == full_pattern);
  assign almost_full_next = (level_next >= AF_LEVEL);

  always_ff @(posedge write_clk) begin
    if (write_reset) begin
      write_binary_count <= '0;
      write_gray_pointer <= '0;
      write_level        <= '0;
      write_full         <= 1'b0;
      write_almost_full  <= 1'b0;
      write_overflow     <= 1'b0;
    end else begin
      write_binary_count <= binary_next;
      write_gray_pointer <= gray_next;
      write_level        <= level_next;
      write_full         <= full_next;
      write_almost_full  <= almost_full_next;
      // A new overflow event beats a simultaneous clear.
      write_overflow     <= (write_inc & write_full) | (write_overflow & ~overflow_clear);
    end
  end

endmodule

// File: tb/tb_write_pointer_level_generate.sv
// tb/tb_write_pointer_level_generate.sv - self-checking bench for write_pointer_level_generate
module tb_write_pointer_level_generate;

  logic       write_clk = 1'b0;
  logic       write_reset;
  logic       write_inc;
  logic [4:0] synchronized_read_pointer2;
  logic       overflow_clear;
  logic       write_accept;
  logic [3:0] write_address;
  logic [4:0] write_gray_pointer;
  logic       write_full;
  logic       write_almost_full;
  logic [4:0] write_level;
  logic       write_overflow;

  write_pointer_level_generate #(.ADDRESS_SIZE(4), .ALMOST_FULL_LEVEL(12)) dut (
    .write_clk                  (write_clk),
    .write_reset                (write_reset),
    .write_inc                  (write_inc),
    .synchronized_read_pointer2 (synchronized_read_pointer2),
    .overflow_clear             (overflow_clear),
    .write_accept               (write_accept),
    .write_address              (write_address),
    .write_gray_pointer         (write_gray_pointer),
    .write_full                 (write_full),
    .write_almost_full          (write_almost_full),
    .write_level                (write_level),
    .write_overflow             (write_overflow)
  );

  always #5 write_clk = ~write_clk;

  int checks = 0;
  int errors = 0;

  // Reference state: total accepted writes and read position, both modulo 32.
  int  m_wr = 0;
  int  m_rd = 0;
  bit  m_full = 0;
  bit  m_af = 0;
  bit  m_ovf = 0;
  int  m_level = 0;
  bit  saw_wrap = 0;
  bit  saw_full_in_lockstep = 0;

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational accept, then registered outputs after the edge.
  task automatic cycle(input bit rst, input bit inc, input int rd, input bit clr);
    bit exp_accept;
    bit old_full;
    write_reset = rst;
    write_inc = inc;
    synchronized_read_pointer2 = gray5(rd);
    overflow_clear = clr;
    #1;
    exp_accept = inc && !m_full;
    chk("write_accept", write_accept, exp_accept);
    @(posedge write_clk);
    old_full = m_full;
    if (rst) begin
      m_wr = 0; m_rd = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (exp_accept) begin
        if (m_wr == 31) saw_wrap = 1;
        m_wr = (m_wr + 1) % 32;
      end
      m_rd = rd % 32;
      m_level = (m_wr - m_rd + 32) % 32;
      m_full = (m_level == 16);
      m_af = (m_level >= 12);
      m_ovf = (inc && old_full) || (m_ovf && !clr);
    end
    #1;
    chk("write_address", write_address, m_wr % 16);
    chk("write_gray_pointer", write_gray_pointer, gray5(m_wr));
    chk("write_level", write_level, m_level);
    chk("write_full", write_full, m_full);
    chk("write_almost_full", write_almost_full, m_af);
    chk("write_overflow", write_overflow, m_ovf);
    @(negedge write_clk);
  endtask

  initial begin
    write_reset = 1'b1;
    write_inc = 1'b0;
    synchronized_read_pointer2 = '0;
    overflow_clear = 1'b0;
    @(negedge write_clk);

    // Reset with a write request pending
    cycle(1, 1, 0, 0);
    chk("reset_level", write_level, 0);
    chk("reset_full", write_full, 0);
    chk("reset_overflow", write_overflow, 0);
    chk("first_addr_after_reset", write_address, 0);

    // Fill with read pointer at 0
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, 0, 0);
      if (i == 11) chk("af_before_12", write_almost_full, 0);
      if (i == 12) chk("af_after_12", write_almost_full, 1);
      if (i == 15) chk("full_before_16", write_full, 0);
    end
    chk("fill_full", write_full, 1);
    chk("fill_level", write_level, 16);
    chk("fill_gray", write_gray_pointer, 5'b11000);
    chk("fill_addr", write_address, 0);

    // Overflow: writes while full are dropped
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    chk("ovf_set", write_overflow, 1);
    chk("ovf_gray_frozen", write_gray_pointer, 5'b11000);
    cycle(0, 0, 0, 1);
    chk("ovf_cleared", write_overflow, 0);
    cycle(0, 1, 0, 1);
    chk("ovf_set_beats_clear", write_overflow, 1);
    cycle(0, 0, 0, 1);
    chk("ovf_cleared2", write_overflow, 0);

    // Drain: read pointer jumps to 16
    cycle(0, 0, 16, 0);
    chk("drain_full", write_full, 0);
    chk("drain_af", write_almost_full, 0);
    chk("drain_level", write_level, 0);

    // Lockstep write/read across the count wrap
    saw_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, m_wr, 0);
      if (write_full !== 1'b0) saw_full_in_lockstep = 1;
      if (write_level > 1) saw_full_in_lockstep = 1;
    end
    chk("lockstep_wrapped", saw_wrap, 1);
    chk("lockstep_no_full", saw_full_in_lockstep, 0);

    // Randomised traffic; the read side only ever trails the write side
    for (int i = 0; i < 300; i++) begin
      int rd;
      rd = m_rd;
      if (((m_wr - m_rd + 32) % 32) > 0 && ($urandom_range(0, 2) == 0))
        rd = (m_rd + $urandom_range(1, (m_wr - m_rd + 32) % 32)) % 32;
      cycle(0, $urandom_range(0, 3) != 0, rd, $urandom_range(0, 7) == 0);
    end

    // Mid-operation reset at level 9
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0);
    chk("pre_reset_level", write_level, 9);
    cycle(1, 1, 0, 0);
    chk("midreset_level", write_level, 0);
    chk("midreset_gray", write_gray_pointer, 0);
    chk("midreset_addr", write_address, 0);
    cycle(0, 1, 0, 0);
    chk("post_reset_addr", write_address, 1);
    chk("post_reset_level", write_level, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
